// File: rtl/multi_player_game_controller.sv
// Multi-player sequence-match game controller.
// Runs the round flow: wait for all players to be allowed, take the round time, request a
// display sequence and a question, then collect answers from NUM_PLAYERS channels. Simultaneous
// answers are arbitrated round-robin. Wrong answerers are locked out for the current question.
// Scores are kept on chip and the game ends on MAX_SCORE or on timeout.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_allow               per-player enable, all set to leave idle
//   i_start               start / continue pulse
//   i_time_enter          round time entered
//   i_timeover            round timer expired (level)
//   i_sequence_done       RNG finished the display sequence
//   i_rand_q              question symbol from RNG
//   i_load, i_in_data     per-player answer strobe and packed answers
//   o_request_seq         level, display sequence requested
//   o_request_q           one-cycle question request
//   o_timer_start         level, round timer running
//   o_q_val               latched question
//   o_pause               correct answer seen
//   o_restart             awaiting time entry
//   o_score               packed player scores
//   o_addpoint            one-cycle score-increment strobe per player
//   o_game_over           game finished
//   o_winner_valid        a player reached MAX_SCORE
//   o_winner              index of the winning player
module multi_player_game_controller #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned SYM_W       = 3,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned MAX_SCORE   = 15,
  parameter int unsigned IDX_W       = 3
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_PLAYERS-1:0]         i_allow,
  input  logic                           i_start,
  input  logic                           i_time_enter,
  input  logic                           i_timeover,
  input  logic                           i_sequence_done,
  input  logic [SYM_W-1:0]               i_rand_q,
  input  logic [NUM_PLAYERS-1:0]         i_load,
  input  logic [NUM_PLAYERS*SYM_W-1:0]   i_in_data,
  output logic                           o_request_seq,
  output logic                           o_request_q,
  output logic                           o_timer_start,
  output logic [SYM_W-1:0]               o_q_val,
  output logic                           o_pause,
  output logic                           o_restart,
  output logic [NUM_PLAYERS*SCORE_W-1:0] o_score,
  output logic [NUM_PLAYERS-1:0]         o_addpoint,
  output logic                           o_game_over,
  output logic                           o_winner_valid,
  output logic [IDX_W-1:0]               o_winner
);

  typedef enum logic [3:0] {
    StIdle, StEnterTime, StWaitStart, StReqSeq, StWaitSeq,
    StFetch, StLoad, StCheck, StCheckEnd, StGameOver
  } state_e;

  localparam logic [SCORE_W-1:0] MaxScore = SCORE_W'(MAX_SCORE);

  state_e                         r_state, r_state_d;
  logic                           r_request_seq, r_request_seq_d;
  logic                           r_request_q, r_request_q_d;
  logic                           r_timer_start, r_timer_start_d;
  logic [SYM_W-1:0]               r_q_val, r_q_val_d;
  logic                           r_pause, r_pause_d;
  logic                           r_restart, r_restart_d;
  logic [NUM_PLAYERS*SCORE_W-1:0] r_score, r_score_d;
  logic [NUM_PLAYERS-1:0]         r_addpoint, r_addpoint_d;
  logic                           r_game_over, r_game_over_d;
  logic                           r_winner_valid, r_winner_valid_d;
  logic [IDX_W-1:0]               r_winner, r_winner_d;
  logic [NUM_PLAYERS-1:0]         r_lockout, r_lockout_d;
  logic [IDX_W-1:0]               r_rr, r_rr_d;
  logic [IDX_W-1:0]               r_grant, r_grant_d;
  logic [SYM_W-1:0]               r_answer, r_answer_d;

  logic [NUM_PLAYERS-1:0] w_eligible;
  logic                   w_found;
  logic [IDX_W-1:0]       w_grant;
  logic [SYM_W-1:0]       w_answer;
  logic [SCORE_W-1:0]     w_cur_score;
  logic                   w_win;
  logic [IDX_W-1:0]       w_win_idx;

  assign w_eligible = i_load & ~r_lockout;

  // Round-robin: first pass from the pointer upward, second pass wraps below it.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!w_found && (i >= int'(r_rr)) && w_eligible[i]) begin
        w_found = 1'b1;
        w_grant = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!w_found && (i < int'(r_rr)) && w_eligible[i]) begin
        w_found = 1'b1;
        w_grant = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_answer    = '0;
    w_cur_score = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (IDX_W'(i) == w_grant) w_answer = i_in_data[i*SYM_W +: SYM_W];
      if (IDX_W'(i) == r_grant) w_cur_score = r_score[i*SCORE_W +: SCORE_W];
    end
  end

  // Lowest-index player at MAX_SCORE wins; scan downward so the lowest assignment sticks.
  always_comb begin
    w_win     = 1'b0;
    w_win_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (r_score[i*SCORE_W +: SCORE_W] == MaxScore) begin
        w_win     = 1'b1;
        w_win_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    r_state_d        = r_state;
    r_request_seq_d  = r_request_seq;
    r_request_q_d    = 1'b0;
    r_timer_start_d  = r_timer_start;
    r_q_val_d        = r_q_val;
    r_pause_d        = r_pause;
    r_restart_d      = r_restart;
    r_score_d        = r_score;
    r_addpoint_d     = r_addpoint;
    r_game_over_d    = r_game_over;
    r_winner_valid_d = r_winner_valid;
    r_winner_d       = r_winner;
    r_lockout_d      = r_lockout;
    r_rr_d           = r_rr;
    r_grant_d        = r_grant;
    r_answer_d       = r_answer;

    unique case (r_state)
      StIdle: begin
        if (&i_allow) begin
          r_restart_d = 1'b1;
          r_state_d   = StEnterTime;
        end
      end
      StEnterTime: begin
        if (i_time_enter) begin
          r_restart_d = 1'b0;
          r_state_d   = StWaitStart;
        end
      end
      StWaitStart: begin
        if (i_start) begin
          r_pause_d       = 1'b0;
          r_lockout_d     = '0;
          r_request_seq_d = 1'b1;
          r_state_d       = StReqSeq;
        end
      end
      StReqSeq: r_state_d = StWaitSeq;
      StWaitSeq: begin
        if (i_sequence_done) begin
          r_request_seq_d = 1'b0;
          r_request_q_d   = 1'b1;
          r_state_d       = StFetch;
        end
      end
      StFetch: begin
        r_q_val_d       = i_rand_q;
        r_timer_start_d = 1'b1;
        r_state_d       = StLoad;
      end
      StLoad: begin
        // A load in the same cycle as timeover takes priority; timeover is seen in CHECK_END.
        if (w_found) begin
          r_grant_d  = w_grant;
          r_answer_d = w_answer;
          r_rr_d     = (w_grant == IDX_W'(NUM_PLAYERS - 1)) ? '0 : w_grant + 1'b1;
          r_state_d  = StCheck;
        end else if (i_timeover) begin
          r_state_d = StCheckEnd;
        end
      end
      StCheck: begin
        if (r_answer == r_q_val) begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (IDX_W'(i) == r_grant) begin
              r_score_d[i*SCORE_W +: SCORE_W] =
                (w_cur_score >= MaxScore) ? MaxScore : w_cur_score + 1'b1;
              r_addpoint_d[i] = 1'b1;
            end
          end
          r_pause_d = 1'b1;
          r_state_d = StCheckEnd;
        end else begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (IDX_W'(i) == r_grant) r_lockout_d[i] = 1'b1;
          end
          r_state_d = (&r_lockout_d) ? StCheckEnd : StLoad;
        end
      end
      StCheckEnd: begin
        r_addpoint_d    = '0;
        r_timer_start_d = 1'b0;
        if (w_win) begin
          r_winner_d       = w_win_idx;
          r_winner_valid_d = 1'b1;
          r_game_over_d    = 1'b1;
          r_state_d        = StGameOver;
        end else if (i_timeover) begin
          r_winner_valid_d = 1'b0;
          r_game_over_d    = 1'b1;
          r_state_d        = StGameOver;
        end else begin
          r_state_d = StWaitStart;
        end
      end
      StGameOver: begin
        if (i_start) begin
          r_score_d        = '0;
          r_game_over_d    = 1'b0;
          r_winner_valid_d = 1'b0;
          r_winner_d       = '0;
          r_restart_d      = 1'b1;
          r_state_d        = StEnterTime;
        end
      end
      default: r_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= StIdle;
      r_request_seq  <= 1'b0;
      r_request_q    <= 1'b0;
      r_timer_start  <= 1'b0;
      r_q_val        <= '0;
      r_pause        <= 1'b0;
      r_restart      <= 1'b0;
      r_score        <= '0;
      r_addpoint     <= '0;
      r_game_over    <= 1'b0;
      r_winner_valid <= 1'b0;
      r_winner       <= '0;
      r_lockout      <= '0;
      r_rr           <= '0;
      r_grant        <= '0;
      r_answer       <= '0;
    end else begin
      r_state        <= r_state_d;
      r_request_seq  <= r_request_seq_d;
      r_request_q    <= r_request_q_d;
      r_timer_start  <= r_timer_start_d;
      r_q_val        <= r_q_val_d;
      r_pause        <= r_pause_d;
      r_restart      <= r_restart_d;
      r_score        <= r_score_d;
      r_addpoint     <= r_addpoint_d;
      r_game_over    <= r_game_over_d;
      r_winner_valid <= r_winner_valid_d;
      r_winner       <= r_winner_d;
      r_lockout      <= r_lockout_d;
      r_rr           <= r_rr_d;
      r_grant        <= r_grant_d;
      r_answer       <= r_answer_d;
    end
  end

  assign o_request_seq  = r_request_seq;
  assign o_request_q    = r_request_q;
  assign o_timer_start  = r_timer_start;
  assign o_q_val        = r_q_val;
  assign o_pause        = r_pause;
  assign o_restart      = r_restart;
  assign o_score        = r_score;
  assign o_addpoint     = r_addpoint;
  assign o_game_over    = r_game_over;
  assign o_winner_valid = r_winner_valid;
  assign o_winner       = r_winner;

endmodule

// File: tb/tb_multi_player_game_controller.sv
// Bench for multi_player_game_controller with four players.
// Stimulus pushes the expected score / game-over events into a queue; a forked monitor pops
// and compares whenever the DUT strobes addpoint or raises game_over.
module tb_multi_player_game_controller;

  localparam int unsigned NP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  allow = '0;
  logic        start = 1'b0, time_enter = 1'b0, timeover = 1'b0, sequence_done = 1'b0;
  logic [2:0]  rand_q = '0;
  logic [3:0]  load = '0;
  logic [11:0] in_data = '0;
  logic        request_seq, request_q, timer_start, pause, restart, game_over, winner_valid;
  logic [2:0]  q_val, winner;
  logic [15:0] score;
  logic [3:0]  addpoint;

  multi_player_game_controller #(
    .NUM_PLAYERS(NP), .SYM_W(3), .SCORE_W(4), .MAX_SCORE(15), .IDX_W(3)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_allow(allow), .i_start(start),
    .i_time_enter(time_enter), .i_timeover(timeover), .i_sequence_done(sequence_done),
    .i_rand_q(rand_q), .i_load(load), .i_in_data(in_data),
    .o_request_seq(request_seq), .o_request_q(request_q), .o_timer_start(timer_start),
    .o_q_val(q_val), .o_pause(pause), .o_restart(restart), .o_score(score),
    .o_addpoint(addpoint), .o_game_over(game_over), .o_winner_valid(winner_valid),
    .o_winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_over;
    logic [3:0]  ap;
    logic [15:0] sc;
    logic        wv;
    logic [2:0]  win;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  exp_sc[NP];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pack_sc();
    logic [15:0] v;
    for (int i = 0; i < NP; i++) v[i*4 +: 4] = 4'(exp_sc[i]);
    return v;
  endfunction

  task automatic push_point(input int p);
    ev_t e;
    exp_sc[p]++;
    e.is_over = 1'b0;
    e.ap      = 4'(1 << p);
    e.sc      = pack_sc();
    e.wv      = 1'b0;
    e.win     = '0;
    sb.push_back(e);
  endtask

  task automatic push_over(input logic wv, input logic [2:0] w);
    ev_t e;
    e.is_over = 1'b1;
    e.ap      = '0;
    e.sc      = pack_sc();
    e.wv      = wv;
    e.win     = w;
    sb.push_back(e);
  endtask

  task automatic monitor();
    logic prev_go = 1'b0;
    ev_t  e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_go = 1'b0;
      end else begin
        if (addpoint != '0) begin
          if (sb.size() == 0) chk("unexpected_addpoint", {28'd0, addpoint}, 32'd0);
          else begin
            e = sb.pop_front();
            chk("event_kind_point", {31'd0, e.is_over}, 32'd0);
            chk("addpoint", {28'd0, addpoint}, {28'd0, e.ap});
            chk("score_at_point", {16'd0, score}, {16'd0, e.sc});
            chk("pause_at_point", {31'd0, pause}, 32'd1);
          end
        end
        if (game_over && !prev_go) begin
          if (sb.size() == 0) chk("unexpected_game_over", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            chk("event_kind_over", {31'd0, e.is_over}, 32'd1);
            chk("winner_valid", {31'd0, winner_valid}, {31'd0, e.wv});
            chk("winner", {29'd0, winner}, {29'd0, e.win});
            chk("score_at_over", {16'd0, score}, {16'd0, e.sc});
            chk("timer_stopped", {31'd0, timer_start}, 32'd0);
          end
        end
        prev_go = game_over;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NP; i++) exp_sc[i] = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // IDLE -> ENTER_TIME -> WAIT_START
  task automatic bring_up();
    for (int i = 0; i < 10 && !restart; i++) @(negedge clk);
    chk("restart_in_enter_time", {31'd0, restart}, 32'd1);
    @(posedge clk); #1 time_enter = 1'b1;
    @(posedge clk); #1 time_enter = 1'b0;
    @(negedge clk);
    chk("restart_cleared", {31'd0, restart}, 32'd0);
  endtask

  // From WAIT_START up to LOAD with question q.
  task automatic round(input logic [2:0] q);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 10 && !request_seq; i++) @(negedge clk);
    chk("request_seq", {31'd0, request_seq}, 32'd1);
    rand_q = q;
    sequence_done = 1'b1;
    for (int i = 0; i < 10 && !request_q; i++) @(negedge clk);
    chk("request_q", {31'd0, request_q}, 32'd1);
    chk("request_seq_dropped", {31'd0, request_seq}, 32'd0);
    sequence_done = 1'b0;
    @(negedge clk);
    chk("request_q_one_cycle", {31'd0, request_q}, 32'd0);
    chk("timer_start", {31'd0, timer_start}, 32'd1);
    chk("q_val", {29'd0, q_val}, {29'd0, q});
  endtask

  task automatic answer(input logic [3:0] mask, input logic [11:0] data);
    @(posedge clk); #1 load = mask; in_data = data;
    @(posedge clk); #1 load = '0;
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic wait_round_end();
    @(negedge clk);
    for (int i = 0; i < 10 && timer_start; i++) @(negedge clk);
    chk("round_ended", {31'd0, timer_start}, 32'd0);
  endtask

  initial begin
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    #2;
    chk("rst_request_seq", {31'd0, request_seq}, 32'd0);
    chk("rst_restart", {31'd0, restart}, 32'd0);
    chk("rst_score", {16'd0, score}, 32'd0);
    chk("rst_game_over", {31'd0, game_over}, 32'd0);
    chk("rst_q_val", {29'd0, q_val}, 32'd0);
    allow = 4'b0111;
    do_reset();
    repeat (3) @(negedge clk);
    chk("idle_needs_all_allow", {31'd0, restart}, 32'd0);
    allow = 4'b1111;

    // Basic round: player 0 answers 5 correctly
    bring_up();
    round(3'd5);
    push_point(0);
    answer(4'b0001, {3'd0, 3'd0, 3'd0, 3'd5});
    wait_round_end();
    chk("pause_held", {31'd0, pause}, 32'd1);
    chk("not_over", {31'd0, game_over}, 32'd0);

    // Round-robin from pointer 0 with all four loading together
    do_reset();
    bring_up();
    for (int r = 0; r < 3; r++) begin
      round(3'd4);
      chk("pause_cleared_on_start", {31'd0, pause}, 32'd0);
      push_point(r);
      answer(4'b1111, {4{3'd4}});
      wait_round_end();
    end

    // Lockout: p1 wrong, p1 again ignored, p0 correct
    round(3'd2);
    answer(4'b0010, {3'd0, 3'd0, 3'd3, 3'd0});
    answer(4'b0010, {3'd0, 3'd0, 3'd2, 3'd0});
    chk("locked_strobe_ignored", {16'd0, score}, {16'd0, pack_sc()});
    push_point(0);
    answer(4'b0001, {3'd0, 3'd0, 3'd0, 3'd2});
    wait_round_end();

    // Everyone wrong: grants walk all four, no point, back to WAIT_START
    round(3'd7);
    for (int k = 0; k < 4; k++) answer(4'b1111, {4{3'd1}});
    wait_round_end();
    chk("all_wrong_scores", {16'd0, score}, {16'd0, pack_sc()});
    chk("all_wrong_no_over", {31'd0, game_over}, 32'd0);

    // Player 0 reaches MAX_SCORE
    do_reset();
    bring_up();
    for (int r = 0; r < 15; r++) begin
      round(3'(r));
      push_point(0);
      if (r == 14) push_over(1'b1, 3'd0);
      answer(4'b0001, {3'd0, 3'd0, 3'd0, 3'(r)});
      wait_round_end();
    end
    @(negedge clk);
    chk("game_over_level", {31'd0, game_over}, 32'd1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < NP; i++) exp_sc[i] = 0;
    @(negedge clk);
    chk("scores_cleared", {16'd0, score}, 32'd0);
    chk("winner_valid_cleared", {31'd0, winner_valid}, 32'd0);
    chk("game_over_cleared", {31'd0, game_over}, 32'd0);
    chk("restart_after_game", {31'd0, restart}, 32'd1);

    // Timeout without answer
    bring_up();
    round(3'd1);
    push_over(1'b0, 3'd0);
    timeover = 1'b1;
    wait_round_end();
    timeover = 1'b0;
    @(negedge clk);
    chk("timeout_game_over", {31'd0, game_over}, 32'd1);

    // Asynchronous reset mid-LOAD
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    bring_up();
    round(3'd3);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_timer_start", {31'd0, timer_start}, 32'd0);
    chk("async_q_val", {29'd0, q_val}, 32'd0);
    chk("async_restart", {31'd0, restart}, 32'd0);
    chk("async_score", {16'd0, score}, 32'd0);
    chk("async_game_over", {31'd0, game_over}, 32'd0);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
